// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO read and write sides.
// Functions work on a wide vector; callers cast to their own pointer width.
package fifo_rd_ctrl_pkg;

   localparam int MAX_PTR_W = 32;

   function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits leave the low bits of the result unaffected.
   function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
      logic [MAX_PTR_W-1:0] b;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_stage.sv
// Showahead output stage: head register, skid register and an in-flight RAM read flag.
// Keeps the head word visible before rd_en and sustains one word per cycle.
module fifo_rd_stage #(
   parameter int DBITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic             mem_empty,
   input  logic [DBITS-1:0] ram_rdata,
   output logic             ram_ren,
   output logic [DBITS-1:0] rd_data,
   output logic             rd_valid,
   output logic [1:0]       stg
);

   logic [DBITS-1:0] head_q, head_d;
   logic [DBITS-1:0] skid_q, skid_d;
   logic             head_v_q, head_v_d;
   logic             skid_v_q, skid_v_d;
   logic             inflight_q, inflight_d;
   logic             pop;

   always_comb begin
      stg        = {1'b0, head_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q};
      pop        = rd_en & head_v_q;
      ram_ren    = ~mem_empty & ((stg - {1'b0, pop}) < 2'd2);
      inflight_d = ram_ren;
      head_d     = head_q;
      head_v_d   = head_v_q;
      skid_d     = skid_q;
      skid_v_d   = skid_v_q;
      if (pop) begin
         head_d   = skid_q;
         head_v_d = skid_v_q;
         skid_v_d = 1'b0;
      end
      // The returning word lands in head whenever head is free after this cycle's pop.
      if (inflight_q) begin
         if (!head_v_d) begin
            head_d   = ram_rdata;
            head_v_d = 1'b1;
         end else begin
            skid_d   = ram_rdata;
            skid_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         skid_q     <= '0;
         head_v_q   <= 1'b0;
         skid_v_q   <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         skid_q     <= skid_d;
         head_v_q   <= head_v_d;
         skid_v_q   <= skid_v_d;
         inflight_q <= inflight_d;
      end
   end

   assign rd_data  = head_v_q ? head_q : '0;
   assign rd_valid = head_v_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointers, registered empty, level and
// almost-empty, with either a normal (1-cycle latency) or showahead output path.
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int SHOWAHEAD     = 1,
   parameter int ABITS         = 10,
   parameter int DBITS         = 16,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic             rdclk,
   input  logic             rst,
   input  logic             rd_en,
   output logic [DBITS-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_empty,
   output logic             rd_almost_empty,
   output logic [ABITS:0]   rd_level,
   output logic             rd_underflow,
   input  logic [ABITS:0]   wptr_gray_sync,
   output logic [ABITS:0]   rptr_gray,
   output logic [ABITS-1:0] ram_raddr,
   output logic             ram_ren,
   input  logic [DBITS-1:0] ram_rdata
);

   localparam int               PTR_W     = ABITS + 1;
   localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AEMPTY_THRESH);

   // Handshake: rd_en is a request. A word is consumed on a clock edge where rd_en=1 and
   // rd_empty=0; rd_en with rd_empty=1 is ignored and reported by rd_underflow next cycle.
   // In showahead mode rd_data/rd_valid present the head word before the request; in normal
   // mode the word appears with rd_valid one cycle after the accepting edge.

   logic [PTR_W-1:0] rbin_q, rbin_d;
   logic [PTR_W-1:0] rptr_gray_q, rptr_gray_d;
   logic [PTR_W-1:0] wbin, mem_level;
   logic             mem_empty_q, mem_empty_d;
   logic             underflow_q, underflow_d;
   logic             ren;
   logic [1:0]       stg;

   always_comb begin
      wbin        = PTR_W'(gray2bin(MAX_PTR_W'(wptr_gray_sync)));
      mem_level   = wbin - rbin_q;
      rbin_d      = rbin_q + PTR_W'(ren);
      rptr_gray_d = PTR_W'(bin2gray(MAX_PTR_W'(rbin_d)));
      mem_empty_d = (rptr_gray_d == wptr_gray_sync);
      underflow_d = rd_en & rd_empty;
   end

   always_ff @(posedge rdclk) begin
      if (rst) begin
         rbin_q      <= '0;
         rptr_gray_q <= '0;
         mem_empty_q <= 1'b1;
         underflow_q <= 1'b0;
      end else begin
         rbin_q      <= rbin_d;
         rptr_gray_q <= rptr_gray_d;
         mem_empty_q <= mem_empty_d;
         underflow_q <= underflow_d;
      end
   end

   generate
      if (SHOWAHEAD == 1) begin : g_showahead
         fifo_rd_stage #(
            .DBITS(DBITS)
         ) u_stage (
            .clk       (rdclk),
            .rst       (rst),
            .rd_en     (rd_en),
            .mem_empty (mem_empty_q),
            .ram_rdata (ram_rdata),
            .ram_ren   (ren),
            .rd_data   (rd_data),
            .rd_valid  (rd_valid),
            .stg       (stg)
         );
         assign rd_empty = ~rd_valid;
      end else begin : g_normal
         logic rd_valid_q, rd_valid_d;

         always_comb begin
            ren        = rd_en & ~mem_empty_q;
            rd_valid_d = ren;
         end

         always_ff @(posedge rdclk) begin
            if (rst) rd_valid_q <= 1'b0;
            else     rd_valid_q <= rd_valid_d;
         end

         assign rd_valid = rd_valid_q;
         assign rd_data  = rd_valid_q ? ram_rdata : '0;
         assign rd_empty = mem_empty_q;
         assign stg      = 2'd0;
      end
   endgenerate

   assign rd_level        = mem_level + PTR_W'(stg);
   assign rd_almost_empty = (rd_level <= AE_THRESH);
   assign rd_underflow    = underflow_q;
   assign rptr_gray       = rptr_gray_q;
   assign ram_raddr       = rbin_q[ABITS-1:0];
   assign ram_ren         = ren;

endmodule
